// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, byte stream out with valid/ready and status pulses.
// The receiver drives through master; the consumer uses slave.
interface uart_rx_if;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      input  uart_rx,
      input  rx_ready,
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy
   );

   modport slave (
      output uart_rx,
      output rx_ready,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, FWFT byte FIFO and
// single-cycle frame_err / overrun pulses.
module uart_rx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input logic       clk_100m,
   input logic       rst_n,
   uart_rx_if.master bus
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB + 1);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int NW   = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [1:0]     r_sync;
   logic           w_rx_s;
   logic [CW-1:0]  r_cnt;
   logic [2:0]     r_bit;
   logic [7:0]     r_shift;
   logic [7:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [NW-1:0]  r_count;
   logic           r_ferr;
   logic           r_ovr;

   logic w_half_hit, w_bit_hit;
   logic w_tick, w_start_ok, w_shift_en, w_stop_smp;
   logic w_full, w_pop, w_push, w_ovr_set, w_ferr_set;

   assign w_rx_s     = r_sync[1];
   assign w_half_hit = (r_cnt == CW'(HALF - 1));
   assign w_bit_hit  = (r_cnt == CW'(CPB - 1));

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], bus.uart_rx};
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!w_rx_s) w_next = S_START;
         S_START: if (w_half_hit) w_next = w_rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (w_bit_hit && r_bit == 3'd7) w_next = S_STOP;
         S_STOP:  if (w_bit_hit) w_next = w_rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (w_rx_s) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_tick     = 1'b0;
      w_start_ok = 1'b0;
      w_shift_en = 1'b0;
      w_stop_smp = 1'b0;
      case (r_state)
         S_START: begin
            w_tick     = w_half_hit;
            w_start_ok = w_half_hit && !w_rx_s;
         end
         S_DATA: begin
            w_tick     = w_bit_hit;
            w_shift_en = w_bit_hit;
         end
         S_STOP: begin
            w_tick     = w_bit_hit;
            w_stop_smp = w_bit_hit;
         end
         default: ;
      endcase
   end

   // Counter idles at zero outside the timed states.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         if (r_state == S_IDLE || r_state == S_BREAK || w_tick)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         if (w_start_ok) r_bit <= '0;
         else if (w_shift_en) r_bit <= r_bit + 1'b1;
         if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
      end
   end

   assign w_full     = (r_count == NW'(FIFO_DEPTH));
   assign w_pop      = bus.rx_valid && bus.rx_ready;
   assign w_push     = w_stop_smp && w_rx_s && (!w_full || w_pop);
   assign w_ovr_set  = w_stop_smp && w_rx_s && w_full && !w_pop;
   assign w_ferr_set = w_stop_smp && !w_rx_s;

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= w_ferr_set;
         r_ovr  <= w_ovr_set;
         if (w_push) begin
            r_mem[r_wptr] <= r_shift;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.rx_valid  = (r_count != '0);
   assign bus.rx_data   = r_mem[r_rptr];
   assign bus.frame_err = r_ferr;
   assign bus.overrun   = r_ovr;
   assign bus.busy      = (r_state != S_IDLE);
endmodule
